mi_accum_ram: RTL and testbench

Parametrised simple-dual-port state memory for the mass-interaction pipeline. It replaces the single-port zero-initialised simulation RAM with a synthesizable block that has:
- an independent read port;
- a write port that either overwrites or saturating-accumulates (force summation onto masses);
- a hardware clear sweep, because an asynchronous reset cannot clear the array.

Read latency stays at 2 cycles, so downstream pipeline alignment is unchanged.

---
 rtl/mi_ram_pkg.sv | 25 ++
 rtl/mi_sdp_array.sv | 30 +++
 rtl/mi_accum_ram.sv | 180 ++++++++++++++++++
 tb/tb_mi_accum_ram.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/mi_ram_pkg.sv
// mi_ram_pkg: shared types and helpers for the mass-interaction state memory.
//   wr_mode_e : how a write commits (overwrite or accumulate onto the stored word)
//   state_e   : clear-sweep / normal-operation states of mi_accum_ram
//   sat_max / sat_min : signed range limits for a given word width (up to 64 bits)
package mi_ram_pkg;

   typedef enum logic {
      WR_OVERWRITE  = 1'b0,
      WR_ACCUMULATE = 1'b1
   } wr_mode_e;

   typedef enum logic {
      ST_CLEAR = 1'b0,
      ST_RUN   = 1'b1
   } state_e;

   function automatic logic signed [63:0] sat_max(input int data_w);
      return (64'sd1 <<< (data_w - 1)) - 64'sd1;
   endfunction

   function automatic logic signed [63:0] sat_min(input int data_w);
      return -(64'sd1 <<< (data_w - 1));
   endfunction

endpackage

// File: rtl/mi_sdp_array.sv
// mi_sdp_array: plain simple-dual-port storage array, no reset on contents.
//   clk            : clock
//   we/waddr/wdata : single write port
//   ra_addr/ra_data: registered read port A (one-cycle latency)
//   rb_addr/rb_data: registered read port B (one-cycle latency)
// Reads return the value held before a same-edge write (read-first).
module mi_sdp_array #(
   parameter int DATA_W = 27,
   parameter int ADDR_W = 5
) (
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [ADDR_W-1:0] ra_addr,
   output logic [DATA_W-1:0] ra_data,
   input  logic [ADDR_W-1:0] rb_addr,
   output logic [DATA_W-1:0] rb_data
);

   logic [DATA_W-1:0] mem [2**ADDR_W];

   always_ff @(posedge clk) begin
      if (we)
         mem[waddr] <= wdata;
      ra_data <= mem[ra_addr];
      rb_data <= mem[rb_addr];
   end

endmodule

// File: rtl/mi_accum_ram.sv
// mi_accum_ram: simple-dual-port state memory with overwrite / saturating-
// accumulate writes and a hardware clear sweep.
//   clk, rst (async, active-high)
//   clear_req          : request a re-zero sweep (ignored while busy)
//   busy               : sweep in progress, read/write requests dropped
//   wr_en/wr_addr/wr_data/wr_acc : write request, acc=1 adds wr_data to the word
//   rd_en/rd_addr      : read request; rd_data/rd_valid two cycles later
//   sat_flag           : sticky accumulate-saturation flag, cleared by a sweep
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_CLEAR | writing 0 to mem[cnt], cnt counts up; leaves after DEPTH-1
// ST_RUN   | normal read/write operation
module mi_accum_ram
   import mi_ram_pkg::*;
#(
   parameter int DATA_W   = 27,
   parameter int ADDR_W   = 5,
   parameter bit SATURATE = 1'b1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clear_req,
   output logic              busy,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              wr_acc,
   input  logic              rd_en,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [DATA_W-1:0] rd_data,
   output logic              rd_valid,
   output logic              sat_flag
);

   localparam logic signed [63:0]       SAT_MAX_64 = sat_max(DATA_W);
   localparam logic signed [63:0]       SAT_MIN_64 = sat_min(DATA_W);
   localparam logic signed [DATA_W-1:0] SAT_MAX    = SAT_MAX_64[DATA_W-1:0];
   localparam logic signed [DATA_W-1:0] SAT_MIN    = SAT_MIN_64[DATA_W-1:0];

   state_e            state, state_nx;
   logic [ADDR_W-1:0] cnt, cnt_nx;

   logic              arr_we;
   logic [ADDR_W-1:0] arr_waddr;
   logic [DATA_W-1:0] arr_wdata;
   logic [DATA_W-1:0] arr_ra_data, arr_rb_data;

   logic              w1_valid, w2_valid;
   logic [ADDR_W-1:0] w1_addr, w2_addr;
   logic [DATA_W-1:0] w1_data, w2_data;
   wr_mode_e          w1_mode, w2_mode;
   logic              w2_fwd;
   logic [DATA_W-1:0] w2_fwd_val;
   logic [DATA_W-1:0] w2_old, w2_result;
   logic [DATA_W:0]   w2_sum;
   logic              w2_ovf, w2_sat_hit;
   logic              commit, run_keep;

   logic              r1_valid, r2_valid, r2_byp;
   logic [ADDR_W-1:0] r1_addr;
   logic [DATA_W-1:0] r2_byp_val;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= ST_CLEAR;
         cnt   <= '0;
      end else begin
         state <= state_nx;
         cnt   <= cnt_nx;
      end
   end

   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      case (state)
         ST_CLEAR: begin
            cnt_nx = cnt + 1'b1;
            if (cnt == {ADDR_W{1'b1}})
               state_nx = ST_RUN;
         end
         ST_RUN: begin
            if (clear_req) begin
               state_nx = ST_CLEAR;
               cnt_nx   = '0;
            end
         end
         default: state_nx = ST_CLEAR;
      endcase
   end

   always_comb begin
      busy      = (state == ST_CLEAR);
      commit    = w2_valid && !busy;
      arr_we    = busy || commit;
      arr_waddr = busy ? cnt : w2_addr;
      arr_wdata = busy ? '0 : w2_result;
   end

   // Anything that would still be in W1/W2 once the sweep starts is dropped.
   assign run_keep = (state == ST_RUN) && (state_nx == ST_RUN);

   // W2: the array value is stale when the previous op (now leaving W2) wrote
   // the same word on the edge the lookup was captured, so take its result.
   always_comb begin
      w2_old     = w2_fwd ? w2_fwd_val : arr_rb_data;
      w2_sum     = {w2_old[DATA_W-1], w2_old} + {w2_data[DATA_W-1], w2_data};
      w2_ovf     = w2_sum[DATA_W] ^ w2_sum[DATA_W-1];
      w2_result  = w2_data;
      w2_sat_hit = 1'b0;
      if (w2_mode == WR_ACCUMULATE) begin
         w2_result = w2_sum[DATA_W-1:0];
         if (SATURATE && w2_ovf) begin
            w2_sat_hit = 1'b1;
            w2_result  = w2_sum[DATA_W] ? SAT_MIN : SAT_MAX;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         w1_valid   <= 1'b0;
         w1_addr    <= '0;
         w1_data    <= '0;
         w1_mode    <= WR_OVERWRITE;
         w2_valid   <= 1'b0;
         w2_addr    <= '0;
         w2_data    <= '0;
         w2_mode    <= WR_OVERWRITE;
         w2_fwd     <= 1'b0;
         w2_fwd_val <= '0;
         r1_valid   <= 1'b0;
         r1_addr    <= '0;
         r2_valid   <= 1'b0;
         r2_byp     <= 1'b0;
         r2_byp_val <= '0;
         sat_flag   <= 1'b0;
      end else begin
         w1_valid   <= wr_en && run_keep;
         w1_addr    <= wr_addr;
         w1_data    <= wr_data;
         w1_mode    <= wr_mode_e'(wr_acc);
         w2_valid   <= w1_valid && run_keep;
         w2_addr    <= w1_addr;
         w2_data    <= w1_data;
         w2_mode    <= w1_mode;
         w2_fwd     <= w1_valid && w2_valid && (w1_addr == w2_addr);
         w2_fwd_val <= w2_result;
         // A read sampled on the last RUN cycle still completes.
         r1_valid   <= rd_en && (state == ST_RUN);
         r1_addr    <= rd_addr;
         r2_valid   <= r1_valid;
         r2_byp     <= r1_valid && commit && (r1_addr == w2_addr);
         r2_byp_val <= w2_result;
         if (busy)
            sat_flag <= 1'b0;
         else if (commit && w2_sat_hit)
            sat_flag <= 1'b1;
      end
   end

   mi_sdp_array #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
   ) u_array (
      .clk     (clk),
      .we      (arr_we),
      .waddr   (arr_waddr),
      .wdata   (arr_wdata),
      .ra_addr (r1_addr),
      .ra_data (arr_ra_data),
      .rb_addr (w1_addr),
      .rb_data (arr_rb_data)
   );

   assign rd_valid = r2_valid;
   assign rd_data  = r2_valid ? (r2_byp ? r2_byp_val : arr_ra_data) : '0;

endmodule

// File: tb/tb_mi_accum_ram.sv
module tb_mi_accum_ram;

   localparam int DW = 27;
   localparam int AW = 5;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          clear_req = 1'b0;
   logic          wr_en = 1'b0;
   logic          wr_acc = 1'b0;
   logic          rd_en = 1'b0;
   logic [AW-1:0] wr_addr = '0;
   logic [AW-1:0] rd_addr = '0;
   logic [DW-1:0] wr_data = '0;

   logic          busy, rd_valid, sat_flag;
   logic [DW-1:0] rd_data;
   logic          busy_w, rd_valid_w, sat_flag_w;
   logic [DW-1:0] rd_data_w;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   mi_accum_ram #(.DATA_W(DW), .ADDR_W(AW), .SATURATE(1'b1)) dut (
      .clk(clk), .rst(rst), .clear_req(clear_req), .busy(busy),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_acc(wr_acc),
      .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid),
      .sat_flag(sat_flag)
   );

   mi_accum_ram #(.DATA_W(DW), .ADDR_W(AW), .SATURATE(1'b0)) dut_wrap (
      .clk(clk), .rst(rst), .clear_req(clear_req), .busy(busy_w),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_acc(wr_acc),
      .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data_w), .rd_valid(rd_valid_w),
      .sat_flag(sat_flag_w)
   );

   task automatic check(input string tag, input longint obs, input longint exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(negedge clk);
   endtask

   task automatic idle();
      wr_en = 1'b0; wr_acc = 1'b0; rd_en = 1'b0; clear_req = 1'b0;
   endtask

   task automatic wr(input int a, input longint d, input bit acc);
      wr_en = 1'b1; wr_addr = AW'(a); wr_data = DW'(d); wr_acc = acc;
   endtask

   task automatic rd_expect(input string tag, input int a, input longint exp);
      rd_en = 1'b1; rd_addr = AW'(a);
      step();
      rd_en = 1'b0;
      check({tag, " early valid"}, rd_valid, 0);
      step();
      check({tag, " valid"}, rd_valid, 1);
      check(tag, $signed(rd_data), exp);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      int vcnt;

      // Reset state and boot sweep length.
      idle();
      repeat (3) step();
      check("rst busy", busy, 1);
      check("rst busy wrap", busy_w, 1);
      check("rst rd_valid", rd_valid, 0);
      check("rst rd_data", rd_data, 0);
      check("rst sat_flag", sat_flag, 0);
      rst = 1'b0;
      n = 0;
      while (busy && n < 100) begin step(); n++; end
      check("boot busy cycles", n, 32);

      // Every word reads 0, valid exactly two cycles after the request.
      for (int i = 0; i < 34; i++) begin
         if (i >= 2) begin
            check("init rd_valid", rd_valid, 1);
            check("init rd_data", rd_data, 0);
         end else begin
            check("init idle rd_valid", rd_valid, 0);
         end
         rd_en = (i < 32); rd_addr = AW'(i);
         step();
      end
      idle();

      // Overwrite then two back-to-back accumulates: 100 + 5 + 5.
      wr(3, 100, 0); step();
      wr(3, 5, 1);   step();
      wr(3, 5, 1);   step();
      idle(); repeat (3) step();
      rd_expect("fwd acc mem3", 3, 110);
      check("sat_flag quiet", sat_flag, 0);

      // Overflow: 67108860+10 clamps to 2^26-1; wraps to 67108870-2^27.
      wr(7, 67108860, 0);  step();
      wr(7, 10, 1);        step();
      wr(8, -67108860, 0); step();
      wr(8, -10, 1);       step();
      idle(); repeat (3) step();
      check("sat_flag set", sat_flag, 1);
      check("sat_flag wrap dut", sat_flag_w, 0);
      rd_en = 1'b1; rd_addr = 7; step();
      rd_addr = 8; step();
      rd_en = 1'b0;
      check("wrap dut rd_valid", rd_valid_w, 1);
      check("sat pos mem7", $signed(rd_data), 67108863);
      check("wrap pos mem7", $signed(rd_data_w), -67108858);
      step();
      check("sat neg mem8", $signed(rd_data), -67108864);
      check("wrap neg mem8", $signed(rd_data_w), 67108858);

      // Same-cycle read sees old value; read one cycle later sees the bypass.
      wr(9, 50, 0); step();
      idle(); repeat (3) step();
      wr(9, 77, 0); rd_en = 1'b1; rd_addr = 9; step();
      wr_en = 1'b0; step();
      rd_en = 1'b0;
      check("same-cycle rd_valid", rd_valid, 1);
      check("same-cycle read old", $signed(rd_data), 50);
      step();
      check("bypass rd_valid", rd_valid, 1);
      check("bypass read new", $signed(rd_data), 77);
      step();
      rd_expect("mem9 settled", 9, 77);

      // Clear with an accumulate in flight and a read sampled just before.
      wr(1, 42, 0); step();
      idle(); repeat (3) step();
      wr(1, 8, 1); step();
      wr_en = 1'b0; clear_req = 1'b1; rd_en = 1'b1; rd_addr = 1; step();
      clear_req = 1'b0; rd_en = 1'b0;
      n = 0; vcnt = 0;
      while (busy && n < 100) begin
         if (n == 1) begin
            check("pre-clear read valid", rd_valid, 1);
            check("pre-clear read data", $signed(rd_data), 42);
         end else if (rd_valid) begin
            vcnt++;
         end
         clear_req = (n == 5);
         rd_en = 1'b1; rd_addr = 1;
         n++;
         step();
      end
      idle();
      check("clear busy cycles", n, 32);
      repeat (2) begin
         if (rd_valid) vcnt++;
         step();
      end
      check("sweep reads dropped", vcnt, 0);
      check("sat_flag cleared", sat_flag, 0);
      rd_expect("mem1 after clear", 1, 0);
      rd_expect("mem3 after clear", 3, 0);
      rd_expect("mem9 after clear", 9, 0);

      // rst mid-sweep at cnt=10 restarts a full sweep; requests dropped.
      wr(20, 5, 0); step();
      idle(); repeat (3) step();
      rd_expect("mem20 preset", 20, 5);
      clear_req = 1'b1; step();
      clear_req = 1'b0;
      repeat (10) step();
      check("mid-sweep busy", busy, 1);
      rst = 1'b1; step();
      check("mid-sweep rst busy", busy, 1);
      rst = 1'b0;
      n = 0; vcnt = 0;
      while (busy && n < 100) begin
         if (rd_valid) vcnt++;
         rd_en = 1'b1; rd_addr = 20;
         wr(20, 99, 0);
         n++;
         step();
      end
      idle();
      check("rst restart busy cycles", n, 32);
      repeat (2) begin
         if (rd_valid) vcnt++;
         step();
      end
      check("rst sweep reads dropped", vcnt, 0);
      repeat (3) step();
      rd_expect("mem20 after rst sweep", 20, 0);
      check("sat_flag after rst", sat_flag, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
